// File: rtl/sf2_issue_scheduler.sv
// Issue scheduler for the SF2 shift/rotate unit: round-robin arbitration between two
// requesters, a 4-stage in-flight scoreboard for RAW blocking, and flush sequencing.
module sf2_issue_scheduler #(
    parameter logic [0:2]  UNIT_ID     = 3'd4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [0:10]              req0_opcode,
    input  logic [0:127]             req0_ra,
    input  logic [0:127]             req0_rb,
    input  logic [0:6]               req0_imm,
    input  logic [0:6]               req0_rt,
    input  logic [0:6]               req0_ra_addr,
    input  logic [0:6]               req0_rb_addr,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [0:10]              req1_opcode,
    input  logic [0:127]             req1_ra,
    input  logic [0:127]             req1_rb,
    input  logic [0:6]               req1_imm,
    input  logic [0:6]               req1_rt,
    input  logic [0:6]               req1_ra_addr,
    input  logic [0:6]               req1_rb_addr,
    output logic [0:127]             sf2_data_ra,
    output logic [0:127]             sf2_data_rb,
    output logic [0:6]               sf2_immediate,
    output logic [0:6]               sf2_addr_rt,
    output logic [0:10]              sf2_opcode,
    output logic                     sf2_flush,
    input  logic [0:138]             sf2_out_data,
    output logic                     busy,
    output logic [0:STALL_CNT_W-1]   stall_cycles
);

    localparam logic [0:STALL_CNT_W-1] STALL_ONE = STALL_CNT_W'(1);

    // Scoreboard: p0 = issue register, p1 = result_reg, p2 = result_reg_1, p3 = out_data.
    logic                   r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
    logic [0:6]             r_rt_p0, r_rt_p1, r_rt_p2, r_rt_p3;
    logic                   r_flush_d;
    logic                   r_rr_ptr;
    logic [0:STALL_CNT_W-1] r_stall;
    logic [0:127]           r_sf2_ra, r_sf2_rb;
    logic [0:6]             r_sf2_imm, r_sf2_rt;
    logic [0:10]            r_sf2_op;

    logic [0:3]   w_sb_vld;
    logic [0:27]  w_sb_rt;
    logic         w_haz0, w_haz1;
    logic         w_elig0, w_elig1;
    logic         w_gnt0, w_gnt1, w_xfer;
    logic         w_sf2_flush;
    logic [0:10]  w_pl_op;
    logic [0:127] w_pl_ra, w_pl_rb;
    logic [0:6]   w_pl_imm, w_pl_rt;
    logic         w_unused_ok;

    function automatic logic f_is_rr(input logic [0:10] op);
        return op[4:6] != 3'b111;
    endfunction

    function automatic logic f_sb_hit(input logic [0:6] addr, input logic [0:3] vld,
                                      input logic [0:27] rts);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && (rts[i*7 +: 7] == addr)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [0:STALL_CNT_W-1] f_sat_inc(input logic [0:STALL_CNT_W-1] v);
        return (&v) ? v : v + STALL_ONE;
    endfunction

    assign w_sb_vld = {r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3};
    assign w_sb_rt  = {r_rt_p0, r_rt_p1, r_rt_p2, r_rt_p3};

    assign w_haz0 = f_sb_hit(req0_ra_addr, w_sb_vld, w_sb_rt)
                  | (f_is_rr(req0_opcode) & f_sb_hit(req0_rb_addr, w_sb_vld, w_sb_rt));
    assign w_haz1 = f_sb_hit(req1_ra_addr, w_sb_vld, w_sb_rt)
                  | (f_is_rr(req1_opcode) & f_sb_hit(req1_rb_addr, w_sb_vld, w_sb_rt));

    assign w_elig0 = req0_valid & ~w_haz0 & ~flush & ~reset;
    assign w_elig1 = req1_valid & ~w_haz1 & ~flush & ~reset;

    // r_rr_ptr = 0 prefers req0 on a tie, 1 prefers req1.
    assign w_gnt0 = w_elig0 & (~w_elig1 | ~r_rr_ptr);
    assign w_gnt1 = w_elig1 & (~w_elig0 |  r_rr_ptr);
    assign w_xfer = w_gnt0 | w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // A flush kills result_reg on the flush edge and again on the following edge.
    assign w_sf2_flush = ~reset & (flush | r_flush_d);

    always_comb begin
        w_pl_op  = '0;
        w_pl_ra  = '0;
        w_pl_rb  = '0;
        w_pl_imm = '0;
        w_pl_rt  = '0;
        if (w_gnt0) begin
            w_pl_op  = req0_opcode;
            w_pl_ra  = req0_ra;
            w_pl_rb  = req0_rb;
            w_pl_imm = req0_imm;
            w_pl_rt  = req0_rt;
        end else if (w_gnt1) begin
            w_pl_op  = req1_opcode;
            w_pl_ra  = req1_ra;
            w_pl_rb  = req1_rb;
            w_pl_imm = req1_imm;
            w_pl_rt  = req1_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_flush_d <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_stall   <= '0;
            r_sf2_op  <= '0;
            r_sf2_ra  <= '0;
            r_sf2_rb  <= '0;
            r_sf2_imm <= '0;
            r_sf2_rt  <= '0;
        end else begin
            r_flush_d <= flush;
            r_vld_p0  <= w_xfer;
            r_vld_p1  <= r_vld_p0;
            r_vld_p2  <= r_vld_p1 & ~w_sf2_flush;
            r_vld_p3  <= r_vld_p2;
            r_sf2_op  <= w_pl_op;
            r_sf2_ra  <= w_pl_ra;
            r_sf2_rb  <= w_pl_rb;
            r_sf2_imm <= w_pl_imm;
            r_sf2_rt  <= w_pl_rt;
            if (w_xfer) r_rr_ptr <= w_gnt0;
            if ((req0_valid | req1_valid) && !w_xfer) r_stall <= f_sat_inc(r_stall);
        end
    end

    // Destination tags only matter while the matching valid bit is set.
    always_ff @(posedge clk) begin
        r_rt_p0 <= w_pl_rt;
        r_rt_p1 <= r_rt_p0;
        r_rt_p2 <= r_rt_p1;
        r_rt_p3 <= r_rt_p2;
    end

    assign sf2_data_ra   = r_sf2_ra;
    assign sf2_data_rb   = r_sf2_rb;
    assign sf2_immediate = r_sf2_imm;
    assign sf2_addr_rt   = r_sf2_rt;
    assign sf2_opcode    = r_sf2_op;
    assign sf2_flush     = w_sf2_flush;
    assign busy          = |w_sb_vld;
    assign stall_cycles  = r_stall;

    assign w_unused_ok = ^{sf2_out_data[0:127], sf2_out_data[131]};

    always @(posedge clk) begin
        if (!reset && r_vld_p3) begin
            assert ((sf2_out_data[132:138] == r_rt_p3) && (sf2_out_data[128:130] == UNIT_ID))
            else $error("sf2_out_data tag %h/%h does not match scoreboard rt %h",
                        sf2_out_data[128:130], sf2_out_data[132:138], r_rt_p3);
        end
    end

endmodule
